// File: rtl/crossbar_ingress.sv
// crossbar_ingress: per-input ingress queue for a 16-port crossbar.
// Words {in_sel, in_data} are queued in a circular FIFO. The head word raises a
// one-hot request toward its destination arbiter and is popped when that
// arbiter grants it.
//
// Optional feature: define CROSSBAR_INGRESS_STARVE_EN to add the wait counter
// and the STARVED state. That state drives `starve` once the head has waited
// STARVE_LIMIT cycles without a grant. With the macro undefined, `starve` is
// tied to 0 and the FSM only uses IDLE and REQ.
//
// Handshake: a word is accepted on a rising edge when in_valid && in_ready.
// in_ready depends only on registered occupancy, never on grant. The head is
// consumed on an edge where count > 0 and grant[out_sel] is high.
module crossbar_ingress #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [3:0]             in_sel,
    output logic [15:0]            request,
    input  logic [15:0]            grant,
    output logic [WIDTH-1:0]       out_data,
    output logic [3:0]             out_sel,
    output logic [$clog2(DEPTH):0] count,
    output logic                   starve
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("crossbar_ingress: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic [WIDTH+3:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;
    logic             drain;

`ifdef CROSSBAR_INGRESS_STARVE_EN
    typedef enum logic [1:0] {IDLE, REQ, STARVED} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

    // FSM state register. Checkers can bind to it by name.
    state_t state;

    assign count    = count_q;
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && grant[out_sel];
    // This pop empties the queue because no push refills it on the same edge.
    assign drain    = pop && !push && (count_q == CW'(1));

    // Head word comes straight from storage at the read pointer.
    // It only changes on a pop, or when a push lands in an empty queue.
    assign {out_sel, out_data} = mem[rd_ptr];

    // Request the head destination arbiter whenever a word is queued.
    always_comb begin
        request = '0;
        if (count_q != '0) begin
            request[out_sel] = 1'b1;
        end
    end

    // Storage write. Contents are not reset, because the pointers and count
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sel, in_data};
        end
    end

    // Pointer and occupancy update. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CROSSBAR_INGRESS_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    logic [WW-1:0] wait_cnt;

    // FSM and wait counter. The counter counts consecutive ungranted cycles of
    // the current head while in REQ, and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= REQ;
                end
                REQ: begin
                    if (drain) begin
                        state <= IDLE;
                    end else if (!pop && wait_cnt == WW'(STARVE_LIMIT - 1)) begin
                        state <= STARVED;
                    end
                end
                STARVED: begin
                    if (pop) state <= drain ? IDLE : REQ;
                end
                default: state <= IDLE;
            endcase

            if (pop || state == IDLE) begin
                wait_cnt <= '0;
            end else if (state == REQ && request != 16'h0000 && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign starve = (state == STARVED);
`else
    // FSM without the starvation state: it only tracks empty versus requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (push)  state <= REQ;
                REQ:     if (drain) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_ingress.sv
// Directed self-checking bench for crossbar_ingress.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Define CROSSBAR_INGRESS_STARVE_EN for both files to exercise the starvation state.
module tb_crossbar_ingress;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_sel;
    logic [15:0]      request;
    logic [15:0]      grant;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_sel;
    logic [3:0]       count;
    logic             starve;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH+3:0] exp_q[$];

    crossbar_ingress #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .request  (request),
        .grant    (grant),
        .out_data (out_data),
        .out_sel  (out_sel),
        .count    (count),
        .starve   (starve)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [3:0] sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_sel(input logic [3:0] sel);
        grant = 16'h0001 << sel;
        step();
        grant = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (request !== 16'h0000) begin n_err++; $display("FAIL reset_request got=%h exp=0000", request); end
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL reset_starve got=%b exp=0", starve); end
        rst = 1'b0;
        step();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL post_reset_count got=%0d exp=0", count); end
        n_cmp++; if (request !== 16'h0000) begin n_err++; $display("FAIL post_reset_request got=%h exp=0000", request); end
    endtask

    task automatic test_single();
        push_word(4'd3, 8'hDD);
        n_cmp++; if (request !== 16'h0008) begin n_err++; $display("FAIL single_request got=%h exp=0008", request); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", count); end
        n_cmp++; if (out_data !== 8'hDD) begin n_err++; $display("FAIL single_data got=%h exp=dd", out_data); end
        n_cmp++; if (out_sel !== 4'd3) begin n_err++; $display("FAIL single_sel got=%0d exp=3", out_sel); end
        pop_sel(4'd3);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        n_cmp++; if (request !== 16'h0000) begin n_err++; $display("FAIL single_pop_request got=%h exp=0000", request); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) push_word(4'(i), 8'(8'h10 + i));
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count got=%0d exp=8", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        push_word(4'd15, 8'hEE);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_ninth_count got=%0d exp=8", count); end
        pop_sel(4'd0);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL full_pop_count got=%0d exp=7", count); end
        for (int i = 1; i < 8; i++) begin
            n_cmp++; if (out_data !== 8'(8'h10 + i)) begin n_err++; $display("FAIL full_drain_data[%0d] got=%h exp=%h", i, out_data, 8'(8'h10 + i)); end
            n_cmp++; if (out_sel !== 4'(i)) begin n_err++; $display("FAIL full_drain_sel[%0d] got=%0d exp=%0d", i, out_sel, i); end
            pop_sel(4'(i));
        end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL full_drained_count got=%0d exp=0", count); end
    endtask

    task automatic test_wrong_grant();
        push_word(4'd0, 8'h5A);
        grant = 16'h0002;
        step();
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL wrong_grant_count got=%0d exp=1", count); end
        n_cmp++; if (request !== 16'h0001) begin n_err++; $display("FAIL wrong_grant_request got=%h exp=0001", request); end
        grant = 16'hFFFE;
        step();
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL other_grants_count got=%0d exp=1", count); end
        grant = 16'h0001;
        step();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL right_grant_count got=%0d exp=0", count); end
        grant = 16'hFFFF;
        step();
        grant = 16'h0000;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_grant_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL empty_grant_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        push_word(4'd2, 8'h21);
        in_valid = 1'b1; in_sel = 4'd9; in_data = 8'h99;
        grant = 16'h0004;
        step();
        in_valid = 1'b0; grant = 16'h0000;
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL b2b_count got=%0d exp=1", count); end
        n_cmp++; if (out_sel !== 4'd9) begin n_err++; $display("FAIL b2b_sel got=%0d exp=9", out_sel); end
        n_cmp++; if (out_data !== 8'h99) begin n_err++; $display("FAIL b2b_data got=%h exp=99", out_data); end
        n_cmp++; if (request !== 16'h0200) begin n_err++; $display("FAIL b2b_request got=%h exp=0200", request); end
        pop_sel(4'd9);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL b2b_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_starve();
        push_word(4'd5, 8'h55);
`ifdef CROSSBAR_INGRESS_STARVE_EN
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_early got=%b exp=0", starve); end
        step();
        n_cmp++; if (starve !== 1'b1) begin n_err++; $display("FAIL starve_set got=%b exp=1", starve); end
        n_cmp++; if (request !== 16'h0020) begin n_err++; $display("FAIL starve_request got=%h exp=0020", request); end
        step();
        n_cmp++; if (starve !== 1'b1) begin n_err++; $display("FAIL starve_hold got=%b exp=1", starve); end
        pop_sel(4'd5);
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_clear got=%b exp=0", starve); end
`else
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_disabled got=%b exp=0", starve); end
        n_cmp++; if (request !== 16'h0020) begin n_err++; $display("FAIL starve_disabled_request got=%h exp=0020", request); end
        pop_sel(4'd5);
`endif
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL starve_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_word(4'(i), 8'(8'hA0 + i));
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mid_count got=%0d exp=0", count); end
        n_cmp++; if (request !== 16'h0000) begin n_err++; $display("FAIL mid_request got=%h exp=0000", request); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        step();
        n_cmp++; if (request !== 16'h0000) begin n_err++; $display("FAIL mid_after_request got=%h exp=0000", request); end
    endtask

    task automatic test_wrap();
        logic [WIDTH+3:0] head;
        logic [WIDTH+3:0] word;
        for (int i = 0; i < 3; i++) begin
            word = {4'(i + 7), 8'(i * 37 + 1)};
            exp_q.push_back(word);
            push_word(word[WIDTH+3:WIDTH], word[WIDTH-1:0]);
        end
        for (int i = 0; i < 20; i++) begin
            head = exp_q[0];
            n_cmp++; if ({out_sel, out_data} !== head) begin n_err++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, {out_sel, out_data}, head); end
            word = {4'(i * 5), 8'(i * 29 + 100)};
            in_valid = 1'b1; in_sel = word[WIDTH+3:WIDTH]; in_data = word[WIDTH-1:0];
            grant = 16'h0001 << head[WIDTH+3:WIDTH];
            step();
            in_valid = 1'b0; grant = 16'h0000;
            exp_q.push_back(word);
            void'(exp_q.pop_front());
            n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL wrap_count[%0d] got=%0d exp=3", i, count); end
        end
        while (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            n_cmp++; if ({out_sel, out_data} !== head) begin n_err++; $display("FAIL wrap_drain got=%h exp=%h", {out_sel, out_data}, head); end
            pop_sel(head[WIDTH+3:WIDTH]);
        end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; grant = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_wrong_grant();
        test_back_to_back();
        test_starve();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crossbar_ingress.md
CROSSBAR_INGRESS -- requirements
Module: crossbar_ingress

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, the FIFO entries; legal values are powers of 2 and at least 2.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, the starvation threshold in cycles.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  space available; a word is accepted when in_valid & in_ready.
- in_data  input  WIDTH  payload.
- in_sel  input  4  destination output port index.
- request  output  16  one-hot request to the crossbar output arbiters.
- grant  input  16  grants from the arbiters, bit k from output k.
- out_data  output  WIDTH  head payload, driven to the crossbar.
- out_sel  output  4  head destination.
- count  output  $clog2(DEPTH)+1  occupancy.
- starve  output  1  head has waited too long.

Function
REQ-005 SHALL store the pair {in_sel, in_data} in a circular FIFO of DEPTH entries.
REQ-006 SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from grant.
REQ-007 SHALL drive request = one-hot(out_sel) when count > 0, and 16'h0000 otherwise; request is combinational from registered head state.
REQ-008 SHALL drive out_data and out_sel from the FIFO head; their value when count == 0 is don't-care but SHALL be stable.
REQ-009 SHALL pop the head on a cycle where count > 0 and grant[out_sel] == 1.
REQ-010 SHALL ignore grant bits other than grant[out_sel], and SHALL ignore any grant while count == 0.
REQ-011 SHALL give one-cycle latency: a word written at edge N into an empty FIFO SHALL assert request after edge N.
REQ-012 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-013 SHALL wrap read and write pointers modulo DEPTH with no gap.
REQ-014 SHALL, when full, hold in_ready = 0 so no push occurs; a pop that cycle raises in_ready on the next cycle.
REQ-015 SHALL implement a FSM with states IDLE, REQ and STARVED:
- IDLE: count == 0.
- IDLE->REQ: on the cycle count becomes nonzero.
- REQ->IDLE: a pop takes count to 0.
- REQ->STARVED: the wait counter reaches STARVE_LIMIT-1 with no grant.
- STARVED->REQ: on a pop leaving count > 0.
- STARVED->IDLE: on a pop leaving count == 0.
REQ-016 SHALL clear the wait counter on every pop and in IDLE, and increment it by 1 per cycle in REQ while request != 0 and no pop occurs; the counter SHALL saturate.
REQ-017 SHALL assert starve only while in STARVED; request SHALL remain asserted while in STARVED.

Reset
REQ-018 SHALL, while rst is high at a clock edge, clear the pointers, count, wait counter and FSM (to IDLE).
REQ-019 SHALL hold these output values during and immediately after reset: in_ready = 1, request = 0, starve = 0, count = 0.
REQ-020 SHALL, on reset mid-operation, discard all queued words without asserting request; RAM contents need not be cleared.

Configuration
REQ-021 SHALL, with CROSSBAR_INGRESS_STARVE_EN defined, include the wait counter and the STARVED state, and drive starve per REQ-015..017.
REQ-022 SHALL, without CROSSBAR_INGRESS_STARVE_EN, omit the wait counter and the STARVED state, and tie starve to 0; all other behaviour is identical.

Verification
REQ-023 SHALL cover this case: after reset, push {sel=3, data=8'hDD} -> request=16'h0008 the next cycle; grant[3]=1 -> count=0 and request=0 the next cycle.
REQ-024 SHALL cover this case: push 8 words with no grant -> in_ready=0 and count=8; a ninth in_valid is not accepted; one grant -> in_ready=1 the next cycle.
REQ-025 SHALL cover this case: head sel=0 with grant=16'h0002 -> no pop and count unchanged; then grant=16'h0001 -> pop.
REQ-026 SHALL cover this case: simultaneous push and pop at count=1 -> count stays 1, and the new head appears with correct out_sel and out_data.
REQ-027 SHALL cover this case: with CROSSBAR_INGRESS_STARVE_EN defined, hold the head 16 cycles ungranted -> starve=1; a grant clears starve the next cycle.
REQ-028 SHALL cover this case: assert rst with count=5 -> count=0, request=0 and in_ready=1 after the edge; 20 wrap-around push/pop cycles keep data in order.
